// File: rtl/mem_pattern_tester.sv
// -----------------------------------------------------------------------------
// mem_pattern_tester
// Wishbone-master memory test engine. It writes a selectable data pattern
// across a window of WORD_COUNT words starting at BASE_ADDR, reads the window
// back, compares each word and reports pass/fail, an error count, details of
// the first failure and a bus timeout flag. A read-only mode skips the write
// phase so that preloaded memories (flash) can be checked.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i                one-cycle start pulse (accepted only in IDLE)
//   mode_i                 0 address, 1 walking-one, 2 LFSR, 3 inverted address
//   seed_i                 LFSR seed (0 is replaced by 1)
//   read_only_i            skip the write phase
//   stop_on_error_i        abort on the first read-phase failure
//   cyc_o/stb_o/we_o/sel_o/addr_o/data_o, data_i/ack_i/err_i   Wishbone master
//   busy_o, done_o, pass_o, timeout_o                          status
//   error_count_o          saturating count of mismatches, bus errors, timeouts
//   fail_addr_o/fail_expected_o/fail_actual_o                  first failure
// -----------------------------------------------------------------------------
module mem_pattern_tester #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    WORD_COUNT     = 1024,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter int                    ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [1:0]               mode_i,
  input  logic [31:0]              seed_i,
  input  logic                     read_only_i,
  input  logic                     stop_on_error_i,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [DATA_WIDTH/8-1:0]  sel_o,
  output logic [ADDR_WIDTH-1:0]    addr_o,
  output logic [DATA_WIDTH-1:0]    data_o,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     ack_i,
  input  logic                     err_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [ERR_CNT_WIDTH-1:0] error_count_o,
  output logic [ADDR_WIDTH-1:0]    fail_addr_o,
  output logic [DATA_WIDTH-1:0]    fail_expected_o,
  output logic [DATA_WIDTH-1:0]    fail_actual_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int POS_W = $clog2(DATA_WIDTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [31:0]           LFSR_MASK = 32'h8020_0003;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORD_COUNT - 1);
  localparam logic [TMR_W-1:0]      TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH
  } state_t;

  state_t state_reg, state_next;

  // latched configuration
  logic [1:0]  mode_reg, mode_next;
  logic [31:0] seed_reg, seed_next;
  logic        soe_reg, soe_next;

  // word sequencing
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [POS_W-1:0]      pos_reg, pos_next;      // i mod DATA_WIDTH
  logic [31:0]           lfsr_reg, lfsr_next;
  logic [ADDR_WIDTH-1:0] word_addr_reg, word_addr_next;
  logic [TMR_W-1:0]      timer_reg, timer_next;

  // registered outputs
  logic                     cyc_reg, cyc_next;
  logic                     stb_reg, stb_next;
  logic                     we_reg, we_next;
  logic [ADDR_WIDTH-1:0]    addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]    data_reg, data_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;
  logic                     pass_reg, pass_next;
  logic                     timeout_reg, timeout_next;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_reg, err_cnt_next;
  logic [ADDR_WIDTH-1:0]    fail_addr_reg, fail_addr_next;
  logic [DATA_WIDTH-1:0]    fail_exp_reg, fail_exp_next;
  logic [DATA_WIDTH-1:0]    fail_act_reg, fail_act_next;

  // ---------------------------------------------------------------------------
  // Pattern generation
  // ---------------------------------------------------------------------------
  logic [31:0]           lfsr_step;
  logic [DATA_WIDTH-1:0] walk_one;
  logic [DATA_WIDTH-1:0] addr_pat;
  logic [DATA_WIDTH-1:0] pattern;

  // Galois LFSR, right shift: mask is folded in when the bit shifted out is 1
  genvar gi;
  generate
    for (gi = 0; gi < 31; gi++) begin : g_lfsr
      assign lfsr_step[gi] = lfsr_reg[gi+1] ^ (lfsr_reg[0] & LFSR_MASK[gi]);
    end
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_walk
      assign walk_one[gi] = (pos_reg == POS_W'(gi));
    end
  endgenerate
  assign lfsr_step[31] = lfsr_reg[0] & LFSR_MASK[31];

  assign addr_pat = DATA_WIDTH'(word_addr_reg);

  always_comb begin
    case (mode_reg)
      2'd0:    pattern = addr_pat;
      2'd1:    pattern = walk_one;
      2'd2:    pattern = lfsr_reg[DATA_WIDTH-1:0];
      default: pattern = ~addr_pat;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake decode (responses only count in a WAIT state)
  // ---------------------------------------------------------------------------
  logic in_wait, resp, bus_err, mismatch, word_fail, timed_out, last_word;

  assign in_wait   = (state_reg == WR_WAIT) || (state_reg == RD_WAIT);
  assign resp      = in_wait && (ack_i || err_i);
  assign bus_err   = in_wait && err_i;           // err_i wins over ack_i
  assign mismatch  = (state_reg == RD_WAIT) && ack_i && !err_i && (data_i != pattern);
  assign word_fail = bus_err || mismatch;
  assign timed_out = in_wait && !ack_i && !err_i && (timer_reg == TMR_LIMIT);
  assign last_word = (idx_reg == LAST_IDX);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = read_only_i ? RD_REQ : WR_REQ;
      WR_REQ:  state_next = WR_WAIT;
      WR_WAIT: begin
        if (timed_out)  state_next = FINISH;
        else if (resp)  state_next = last_word ? RD_REQ : WR_REQ;
      end
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: begin
        if (timed_out) state_next = FINISH;
        else if (resp) state_next = ((word_fail && soe_reg) || last_word) ? FINISH : RD_REQ;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_next      = mode_reg;
    seed_next      = seed_reg;
    soe_next       = soe_reg;
    idx_next       = idx_reg;
    pos_next       = pos_reg;
    lfsr_next      = lfsr_reg;
    word_addr_next = word_addr_reg;
    timer_next     = timer_reg;
    cyc_next       = cyc_reg;
    stb_next       = stb_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    busy_next      = busy_reg;
    done_next      = done_reg;
    pass_next      = pass_reg;
    timeout_next   = timeout_reg;
    err_cnt_next   = err_cnt_reg;
    fail_addr_next = fail_addr_reg;
    fail_exp_next  = fail_exp_reg;
    fail_act_next  = fail_act_reg;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          mode_next      = mode_i;
          seed_next      = (seed_i == 32'd0) ? 32'd1 : seed_i;
          soe_next       = stop_on_error_i;
          lfsr_next      = (seed_i == 32'd0) ? 32'd1 : seed_i;
          idx_next       = '0;
          pos_next       = '0;
          word_addr_next = BASE_ADDR;
          busy_next      = 1'b1;
          done_next      = 1'b0;
          pass_next      = 1'b0;
          timeout_next   = 1'b0;
          err_cnt_next   = '0;
          fail_addr_next = '0;
          fail_exp_next  = '0;
          fail_act_next  = '0;
        end
      end

      WR_REQ, RD_REQ: begin
        cyc_next   = 1'b1;
        stb_next   = 1'b1;
        we_next    = (state_reg == WR_REQ);
        addr_next  = word_addr_reg;
        data_next  = (state_reg == WR_REQ) ? pattern : '0;
        timer_next = '0;
      end

      WR_WAIT, RD_WAIT: begin
        if (resp || timed_out) begin
          cyc_next = 1'b0;
          stb_next = 1'b0;
          we_next  = 1'b0;
        end
        if (timed_out) timeout_next = 1'b1;
        if (word_fail || timed_out) begin
          if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + ERR_CNT_WIDTH'(1);
          // a zero count means nothing has failed yet in this run
          if (err_cnt_reg == '0) begin
            fail_addr_next = word_addr_reg;
            fail_exp_next  = pattern;
            fail_act_next  = mismatch ? data_i : '0;
          end
        end
        if (resp) begin
          if (last_word) begin
            // rewind; reloading the seed makes read expectations replay the write sequence
            idx_next       = '0;
            pos_next       = '0;
            word_addr_next = BASE_ADDR;
            lfsr_next      = seed_reg;
          end else begin
            idx_next       = idx_reg + IDX_W'(1);
            pos_next       = pos_reg + POS_W'(1);
            word_addr_next = word_addr_reg + ADDR_STEP;
            lfsr_next      = lfsr_step;
          end
        end else if (!timed_out) begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end

      FINISH: begin
        busy_next = 1'b0;
        done_next = 1'b1;
        pass_next = (err_cnt_reg == '0) && !timeout_reg;
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_reg      <= '0;
      seed_reg      <= '0;
      soe_reg       <= 1'b0;
      idx_reg       <= '0;
      pos_reg       <= '0;
      lfsr_reg      <= '0;
      word_addr_reg <= '0;
      timer_reg     <= '0;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      pass_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      err_cnt_reg   <= '0;
      fail_addr_reg <= '0;
      fail_exp_reg  <= '0;
      fail_act_reg  <= '0;
    end else begin
      mode_reg      <= mode_next;
      seed_reg      <= seed_next;
      soe_reg       <= soe_next;
      idx_reg       <= idx_next;
      pos_reg       <= pos_next;
      lfsr_reg      <= lfsr_next;
      word_addr_reg <= word_addr_next;
      timer_reg     <= timer_next;
      cyc_reg       <= cyc_next;
      stb_reg       <= stb_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      pass_reg      <= pass_next;
      timeout_reg   <= timeout_next;
      err_cnt_reg   <= err_cnt_next;
      fail_addr_reg <= fail_addr_next;
      fail_exp_reg  <= fail_exp_next;
      fail_act_reg  <= fail_act_next;
    end
  end

  assign cyc_o           = cyc_reg;
  assign stb_o           = stb_reg;
  assign we_o            = we_reg;
  assign sel_o           = '1;
  assign addr_o          = addr_reg;
  assign data_o          = data_reg;
  assign busy_o          = busy_reg;
  assign done_o          = done_reg;
  assign pass_o          = pass_reg;
  assign timeout_o       = timeout_reg;
  assign error_count_o   = err_cnt_reg;
  assign fail_addr_o     = fail_addr_reg;
  assign fail_expected_o = fail_exp_reg;
  assign fail_actual_o   = fail_act_reg;

endmodule

// File: tb/tb_mem_pattern_tester.sv
// -----------------------------------------------------------------------------
// tb_mem_pattern_tester
// Scoreboard bench: each run pushes the expected bus transactions and the
// expected final result into queues; independent monitors pop and compare as
// the DUT completes transfers and raises done_o. A Wishbone slave with a small
// RAM supplies random latency, a stuck-bit fault, a hung write and ack+err.
// -----------------------------------------------------------------------------
module tb_mem_pattern_tester;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam logic [31:0] BASE = 32'h0020_0000;
  localparam int          WC   = 16;
  localparam int          TMO  = 8;
  localparam int          EW   = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [1:0]    mode_i;
  logic [31:0]   seed_i;
  logic          read_only_i;
  logic          stop_on_error_i;
  logic          cyc_o, stb_o, we_o;
  logic [3:0]    sel_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic [DW-1:0] data_i;
  logic          ack_i, err_i;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [EW-1:0] error_count_o;
  logic [AW-1:0] fail_addr_o;
  logic [DW-1:0] fail_expected_o, fail_actual_o;

  mem_pattern_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
    .WORD_COUNT(WC), .TIMEOUT_CYCLES(TMO), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .seed_i(seed_i), .read_only_i(read_only_i), .stop_on_error_i(stop_on_error_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
    .addr_o(addr_o), .data_o(data_o), .data_i(data_i), .ack_i(ack_i), .err_i(err_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .error_count_o(error_count_o), .fail_addr_o(fail_addr_o),
    .fail_expected_o(fail_expected_o), .fail_actual_o(fail_actual_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    bit          pass;
    logic [15:0] errs;
    bit          tmo;
    bit          chk_fail;
    logic [31:0] faddr;
    logic [31:0] fexp;
    logic [31:0] fact;
  } res_t;

  txn_t exp_q[$];
  res_t res_q[$];

  int total = 0;
  int bad   = 0;
  bit scb_en = 1'b1;

  // slave configuration
  logic [31:0] mem [WC];
  logic [31:0] ro_img [WC];
  int          fault_word = -1;
  logic [31:0] fault_mask = '0;
  int          noack_word = -1;
  int          err_word   = -1;
  int          max_lat    = 3;
  int          last_len   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // reference: pattern of word i, derived directly from the pattern rules
  function automatic logic [31:0] model_pattern(input int mode, input int i, input logic [31:0] seed);
    logic [31:0] a;
    logic [31:0] s;
    a = BASE + 32'(i * 4);
    case (mode)
      0: return a;
      1: begin s = 32'h1; return s << (i % 32); end
      2: begin
        s = (seed == 32'd0) ? 32'd1 : seed;
        for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        return s;
      end
      default: return ~a;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Wishbone slave: drives responses 1 time unit after each rising edge
  // ---------------------------------------------------------------------------
  initial begin
    int wc;
    int lat;
    int w;
    ack_i = 1'b0; err_i = 1'b0; data_i = '0; wc = 0; lat = 0;
    forever begin
      @(posedge clk_i); #1;
      ack_i = 1'b0;
      err_i = 1'b0;
      if (cyc_o && stb_o && !rst_i) begin
        w = int'((addr_o - BASE) >> 2);
        if (wc == 0) lat = $urandom_range(0, max_lat);
        if (we_o && w == noack_word) begin
          // hold the bus hung
        end else if (wc >= lat) begin
          ack_i = 1'b1;
          if (!we_o && w == err_word) err_i = 1'b1;
          if (we_o) mem[w] = data_o;
          else      data_i = mem[w] | ((w == fault_word) ? fault_mask : 32'h0);
          wc = 0;
        end else begin
          wc++;
        end
      end else begin
        wc = 0;
      end
    end
  end

  // strobe pulse length, in cycles
  initial begin
    int cur;
    cur = 0;
    forever begin
      @(posedge clk_i); #1;
      if (stb_o) cur++;
      else if (cur > 0) begin last_len = cur; cur = 0; end
    end
  end

  // transaction monitor
  initial begin
    txn_t t;
    forever begin
      @(negedge clk_i);
      if (scb_en && cyc_o && stb_o && (ack_i || err_i)) begin
        $display("txn we=%0d addr=%h wdata=%h rdata=%h ack=%0d err=%0d",
                 we_o, addr_o, data_o, data_i, ack_i, err_i);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_txn actual=addr %h required=none", addr_o);
        end else begin
          t = exp_q.pop_front();
          chk("txn_we", 64'(we_o), 64'(t.we));
          chk("txn_addr", 64'(addr_o), 64'(t.addr));
          if (t.we) chk("txn_wdata", 64'(data_o), 64'(t.data));
        end
      end
    end
  end

  // result monitor
  initial begin
    res_t r;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (scb_en && done_o && !done_prev) begin
        if (res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          r = res_q.pop_front();
          $display("result pass=%0d errs=%0d timeout=%0d", pass_o, error_count_o, timeout_o);
          chk("res_pass", 64'(pass_o), 64'(r.pass));
          chk("res_errs", 64'(error_count_o), 64'(r.errs));
          chk("res_timeout", 64'(timeout_o), 64'(r.tmo));
          chk("res_busy", 64'(busy_o), 64'd0);
          if (r.chk_fail) begin
            chk("res_fail_addr", 64'(fail_addr_o), 64'(r.faddr));
            chk("res_fail_exp", 64'(fail_expected_o), 64'(r.fexp));
            chk("res_fail_act", 64'(fail_actual_o), 64'(r.fact));
          end
        end
      end
      done_prev = done_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cyc"}, 64'(cyc_o), 64'd0);
    chk({tag, "_stb"}, 64'(stb_o), 64'd0);
    chk({tag, "_we"}, 64'(we_o), 64'd0);
    chk({tag, "_sel"}, 64'(sel_o), 64'hF);
    chk({tag, "_addr"}, 64'(addr_o), 64'd0);
    chk({tag, "_data"}, 64'(data_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_pass"}, 64'(pass_o), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout_o), 64'd0);
    chk({tag, "_errs"}, 64'(error_count_o), 64'd0);
    chk({tag, "_fail_addr"}, 64'(fail_addr_o), 64'd0);
    chk({tag, "_fail_exp"}, 64'(fail_expected_o), 64'd0);
    chk({tag, "_fail_act"}, 64'(fail_actual_o), 64'd0);
  endtask

  task automatic run(input int mode, input logic [31:0] seed, input bit ro, input bit soe,
                     input int fw, input logic [31:0] fmask, input int nw, input int ew,
                     input bit chk_lat, input bit extra_start);
    res_t        r;
    txn_t        t;
    logic [31:0] pat;
    logic [31:0] rd;
    int          errs;
    bit          hung;
    int          n;
    fault_word = fw; fault_mask = fmask; noack_word = nw; err_word = ew;
    r.pass = 0; r.errs = '0; r.tmo = 0; r.chk_fail = 1;
    r.faddr = '0; r.fexp = '0; r.fact = '0;
    errs = 0; hung = 0;
    if (!ro) begin
      for (int i = 0; i < WC; i++) begin
        if (i == nw) begin hung = 1; break; end
        t.we = 1; t.addr = BASE + 32'(i * 4); t.data = model_pattern(mode, i, seed);
        exp_q.push_back(t);
      end
    end
    if (hung) begin
      r.tmo = 1; errs = 1; r.chk_fail = 0;
    end else begin
      for (int i = 0; i < WC; i++) begin
        pat = model_pattern(mode, i, seed);
        rd  = (ro ? ro_img[i] : pat) | ((i == fw) ? fmask : 32'h0);
        t.we = 0; t.addr = BASE + 32'(i * 4); t.data = '0;
        exp_q.push_back(t);
        if (i == ew || rd != pat) begin
          errs++;
          if (errs == 1) begin
            r.faddr = t.addr; r.fexp = pat; r.fact = (i == ew) ? 32'h0 : rd;
          end
          if (soe) break;
        end
      end
    end
    r.errs = 16'(errs);
    r.pass = (errs == 0) && !r.tmo;
    res_q.push_back(r);

    @(posedge clk_i); #1;
    start_i = 1'b1; mode_i = 2'(mode); seed_i = seed;
    read_only_i = ro; stop_on_error_i = soe;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
    if (chk_lat) begin
      chk("stb_lat_cycle1", 64'(stb_o), 64'd0);
      @(posedge clk_i); #1;
      chk("stb_lat_cycle2", 64'(stb_o), 64'd1);
    end
    if (extra_start) begin
      repeat (4) @(posedge clk_i);
      #1;
      start_i = 1'b1; mode_i = 2'd3; read_only_i = 1'b0;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      chk("busy_start_ignored", 64'(busy_o), 64'd1);
      chk("done_start_ignored", 64'(done_o), 64'd0);
    end
    n = 0;
    while (!done_o && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!done_o) begin
      total++; bad++;
      $display("FAIL wait_done actual=timeout required=done_o");
    end
    @(negedge clk_i);
    @(negedge clk_i);
    chk("txn_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    res_q.delete();
  endtask

  initial begin
    int n;
    int fw;
    int ew;
    rst_i = 1'b1; start_i = 1'b0; mode_i = '0; seed_i = '0;
    read_only_i = 1'b0; stop_on_error_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_i = 1'b0;

    // address pattern, start latency
    run(0, 32'h0, 0, 0, -1, 32'h0, -1, -1, 1, 0);
    // LFSR from a zero seed and from a fixed seed
    run(2, 32'h0, 0, 0, -1, 32'h0, -1, -1, 0, 0);
    run(2, 32'hDEAD_BEEF, 0, 0, -1, 32'h0, -1, -1, 0, 0);
    // stuck-at-1 on bit 5 of word 3, walking one, without and with abort
    run(1, 32'h0, 0, 0, 3, 32'h20, -1, -1, 0, 0);
    run(1, 32'h0, 0, 1, 3, 32'h20, -1, -1, 0, 0);
    // hung write of word 5
    run(0, 32'h0, 0, 0, -1, 32'h0, 5, -1, 0, 0);
    chk("timeout_stb_len", 64'(last_len), 64'd9);
    // ack and err together on read of word 7
    run(3, 32'h0, 0, 0, -1, 32'h0, -1, 7, 0, 0);

    // reset in the middle of a transfer
    scb_en = 1'b0;
    noack_word = 2;
    @(posedge clk_i); #1;
    start_i = 1'b1; mode_i = 2'd0; read_only_i = 1'b0; stop_on_error_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0;
    while (!(stb_o && addr_o == BASE + 32'd8) && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("midreset_reached_stb", 64'(stb_o), 64'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_reset_outputs("midreset");
    rst_i = 1'b0;
    noack_word = -1;
    exp_q.delete();
    res_q.delete();
    @(negedge clk_i);
    scb_en = 1'b1;

    // read-only against a preloaded address image, with a start while busy
    for (int i = 0; i < WC; i++) begin
      ro_img[i] = BASE + 32'(i * 4);
      mem[i]    = ro_img[i];
    end
    run(0, 32'h0, 1, 0, -1, 32'h0, -1, -1, 0, 1);

    // randomized runs
    for (int k = 0; k < 8; k++) begin
      fw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, WC - 1)) : -1;
      ew = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WC - 1)) : -1;
      run(int'($urandom_range(0, 3)), $urandom(), 0, bit'($urandom_range(0, 1)),
          fw, 32'h1 << $urandom_range(0, 31), -1, ew, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
